alu_md_unit: RTL

- Parametrised execute-stage unit for the pipelined RISC-V core.
- Replaces the fixed 3-bit ALU function decode with a full RV32I ALU decode plus the optional RV32M multiply/divide ops.
- Single-cycle ops return one cycle after acceptance. MUL/DIV ops run an iterative sequencer; the unit holds `busy` so hazard logic stalls IF/ID/EX for the duration.

---
 rtl/alu_md_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with full RV32I decode and optional iterative RV32M multiply/divide.
// Single-cycle ops answer one cycle after acceptance; MUL/DIV hold busy for XLEN+1 cycles.
module alu_md_unit #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      fun3,
  input  logic [6:0]      fun7,
  input  logic            op5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            out_valid,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] LAST = SW'(XLEN - 1);
  localparam logic M_ON = (ENABLE_M != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [1:0]        state;
  logic [SW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        op_f3;
  logic              neg_res;

  assign in_ready = (state == S_IDLE) && !reset;
  assign busy     = (state != S_IDLE);

  // Base RV32I ALU
  logic [SW-1:0]          shamt;
  logic signed [XLEN-1:0] sra_out;
  logic [XLEN-1:0]        alu_out;

  assign shamt   = src_b[SW-1:0];
  assign sra_out = $signed(src_a) >>> shamt;

  always_comb begin
    alu_out = src_a + src_b;
    case (ALUOp)
      2'b01: alu_out = src_a - src_b;
      2'b10: begin
        case (fun3)
          3'b000:  alu_out = (fun7[5] && op5) ? (src_a - src_b) : (src_a + src_b);
          3'b001:  alu_out = src_a << shamt;
          3'b010:  alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
          3'b011:  alu_out = {{(XLEN-1){1'b0}}, (src_a < src_b)};
          3'b100:  alu_out = src_a ^ src_b;
          3'b101:  alu_out = fun7[5] ? sra_out : (src_a >> shamt);
          3'b110:  alu_out = src_a | src_b;
          default: alu_out = src_a & src_b;
        endcase
      end
      default: alu_out = src_a + src_b;
    endcase
  end

  // M-op decode and operand preparation at acceptance
  logic            is_m, is_div, a_sgn, b_sgn, a_neg, b_neg, neg_n;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    is_m        = M_ON && (ALUOp == 2'b10) && op5 && (fun7 == 7'b0000001);
    is_div      = fun3[2];
    a_sgn       = is_div ? !fun3[0] : (fun3[1:0] != 2'b11);
    b_sgn       = is_div ? !fun3[0] : !fun3[1];
    a_neg       = a_sgn && src_a[XLEN-1];
    b_neg       = b_sgn && src_b[XLEN-1];
    a_mag       = a_neg ? -src_a : src_a;
    b_mag       = b_neg ? -src_b : src_b;
    // Remainder takes the dividend's sign; products and quotients the XOR of both
    neg_n       = (is_div && fun3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero    = (src_b == '0);
    div_ovf     = !fun3[0] && (src_a == MIN_NEG) && (src_b == ALL_ONES);
    special     = is_div && (div_zero || div_ovf);
    special_res = div_zero ? (fun3[1] ? src_a : ALL_ONES)
                           : (fun3[1] ? '0 : src_a);
  end

  // One shift-add or restoring-division step per cycle; acc = {hi, lo}
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod_fix;
  logic [XLEN-1:0]   div_pick, div_fix, fin_res;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_next  = (state == S_DIV) ? div_next : mul_next;
    prod_fix  = neg_res ? -mul_next : mul_next;
    div_pick  = op_f3[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    div_fix   = neg_res ? -div_pick : div_pick;
    if (state == S_DIV)
      fin_res = div_fix;
    else if (op_f3[1:0] == 2'b00)
      fin_res = prod_fix[XLEN-1:0];
    else
      fin_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Sequencer: reset beats flush, flush beats accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op_f3     <= '0;
      neg_res   <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (!is_m) begin
              result    <= alu_out;
              zero      <= (alu_out == '0);
              out_valid <= 1'b1;
            end else if (special) begin
              result    <= special_res;
              zero      <= (special_res == '0);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              op_f3   <= fun3;
              neg_res <= neg_n;
              cnt     <= '0;
              if (is_div) begin
                acc   <= {{XLEN{1'b0}}, a_mag};
                opnd  <= b_mag;
                state <= S_DIV;
              end else begin
                acc   <= {{XLEN{1'b0}}, b_mag};
                opnd  <= a_mag;
                state <= S_MUL;
              end
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= acc_next;
          cnt <= cnt + SW'(1);
          if (cnt == LAST) begin
            result    <= fin_res;
            zero      <= (fin_res == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
